fad_cell: RTL and testbench
===========================

// Module: fad_cell
// PURPOSE
//  Full-adder cell: adds operands a, b and carry-in cin, producing sum and carry-out.
//  - Bit-level arithmetic leaf; chained into ripple adders elsewhere in the design.
//  - Width-parameterised ripple of 1-bit full-adder slices.
//  - Output is registered by default; a combinational option is available.
// PARAMETERS
//  WIDTH    1   operand width in bits (>=1); WIDTH=1 is the classic single full adder
//  REG_OUT  1   1: sum/cout registered on clk (1-cycle latency); 0: purely combinational
// PORTS
//  clk   in   1      single clock, rising edge
//  rst   in   1      synchronous, active-high reset
//  a     in   WIDTH  operand A
//  b     in   WIDTH  operand B
//  cin   in   1      carry-in into bit 0
//  sum   out  WIDTH  (a + b + cin) mod 2^WIDTH
//  cout  out  1      carry out of bit WIDTH-1
//  Port order: clk, rst, a, b, cin, sum, cout.
// BEHAVIOUR
//  - Per slice i: s[i] = a[i] ^ b[i] ^ c[i]
//  - Per slice i: c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
//  - Carry chain: c[0] = cin; cout = c[WIDTH].
//  - Arithmetic: {cout, sum} == a + b + cin, evaluated at WIDTH+1 bits, unsigned; no overflow flag.
//  - REG_OUT=1:
//    - sum/cout update on rising clk from the inputs sampled at that edge.
//    - Latency: exactly 1 cycle.
//    - New inputs are accepted every cycle; no handshake and no stall.
//  - REG_OUT=1, reset:
//    - rst=1 at a rising edge forces sum=0 and cout=0, regardless of the inputs.
//    - Reset overrides a simultaneous input change.
//    - Reset mid-stream discards the in-flight result.
//    - First valid result appears on the first edge after rst deasserts.
//  - REG_OUT=0:
//    - sum/cout follow the inputs combinationally, with zero latency.
//    - clk and rst are unused (kept for a uniform interface).
//  - Boundaries:
//    - All-ones + all-ones + cin=1 -> sum=all-ones, cout=1.
//    - All-zero inputs -> sum=0, cout=0.
//    - cin alone propagates through a full all-ones carry chain (max ripple path).
//  - X on any input propagates to the outputs; no X-masking.
// STRUCTURE
//  - Shared package: none required; no typedefs or constants are shared.
//  - Sub-module fad_bit (a, b, ci -> s, co):
//    - Pure combinational 1-bit slice.
//    - Instantiated WIDTH times via generate, with the carry chained slice to slice.
//  - Top level: generate loop, optional output register block selected by REG_OUT, reset logic.
// TESTING
//  - WIDTH=1, REG_OUT=0, exhaustive sweep of the 8 input combinations:
//    - (a,b,cin)=(0,0,0)->(sum,cout)=(0,0)
//    - (0,0,1)->(1,0)
//    - (1,0,0)->(1,0)
//    - (0,1,1)->(0,1)
//    - (1,1,0)->(0,1)
//    - (1,1,1)->(1,1)
//    - remaining two combinations checked against a+b+cin.
//  - WIDTH=1, REG_OUT=1, latency check:
//    - Drive (1,1,1) before an edge -> sum=1, cout=1 visible after that edge, not before.
//    - Prior value held until the edge.
//  - WIDTH=1, REG_OUT=1, reset check:
//    - Hold rst=1 with (1,1,1) applied -> sum=0, cout=0 on every edge while reset.
//    - Release rst -> (1,1) after the next edge.
//  - WIDTH=8, REG_OUT=1, carry chain and overflow:
//    - a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1 (full ripple).
//    - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  - WIDTH=8, back-to-back throughput:
//    - A new random (a,b,cin) every cycle for 1000 cycles.
//    - Each result equals a+b+cin from one cycle earlier.
//  - Mid-stream reset:
//    - Assert rst for one cycle during random traffic -> outputs 0 for that edge.
//    - Correct results resume on the following edge.

Source files
------------

// File: rtl/fad_bit.sv
// Single-bit full-adder slice: purely combinational leaf of the ripple chain.
module fad_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry-out of one bit position
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/fad_cell.sv
// Width-parameterised ripple-carry adder built from fad_bit slices, with an
// optional registered output stage (REG_OUT=1) or a pure combinational path.
module fad_cell #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        fad_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry_s[i]),
            .s  (sum_s[i]),
            .co (carry_s[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_r;
        logic             cout_r;

        // Output register; reset wins over any input change on the same edge
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_r  <= {WIDTH{1'b0}};
                cout_r <= 1'b0;
            end else begin
                sum_r  <= sum_s;
                cout_r <= carry_s[WIDTH];
            end
        end

        assign sum  = sum_r;
        assign cout = cout_r;
    end else begin : g_comb
        // clk/rst exist only so both variants share one interface
        logic unused_s;
        assign unused_s = clk ^ rst;

        assign sum  = sum_s;
        assign cout = carry_s[WIDTH];
    end

endmodule

// File: tb/tb_fad_cell.sv
// Self-checking bench for fad_cell: combinational 1-bit sweep, registered
// 1-bit latency/reset sequences, and 8-bit directed plus random streams.
module tb_fad_cell;

    logic clk;
    logic rst1, rst8;

    logic       a1c, b1c, cin1c, sum1c, cout1c;
    logic       a1r, b1r, cin1r, sum1r, cout1r;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;

    int errors = 0;
    int checks = 0;

    fad_cell #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
        .clk(clk), .rst(rst1), .a(a1c), .b(b1c), .cin(cin1c), .sum(sum1c), .cout(cout1c)
    );

    fad_cell #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (
        .clk(clk), .rst(rst1), .a(a1r), .b(b1r), .cin(cin1r), .sum(sum1r), .cout(cout1r)
    );

    fad_cell #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic sum;
        logic cout;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec8_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain unsigned addition at WIDTH+1 bits
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return t[8:0];
    endfunction

    vec1_t tab1[8];
    vec8_t tab8[5];

    initial begin
        logic [8:0] e;
        int rst_cycle;

        tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tab1[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tab1[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab1[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tab1[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tab1[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        tab8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        tab8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tab8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tab8[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        tab8[4] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};

        rst1 = 1'b1; rst8 = 1'b1;
        a1c = 1'b0; b1c = 1'b0; cin1c = 1'b0;
        a1r = 1'b0; b1r = 1'b0; cin1r = 1'b0;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;

        // Reset state of both registered instances
        repeat (2) @(posedge clk);
        #1;
        chk("rst_w1_sum", 32'(sum1r), 32'd0);
        chk("rst_w1_cout", 32'(cout1r), 32'd0);
        chk("rst_w8_sum", 32'(sum8), 32'd0);
        chk("rst_w8_cout", 32'(cout8), 32'd0);

        // WIDTH=1 combinational exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            a1c = tab1[i].a; b1c = tab1[i].b; cin1c = tab1[i].cin;
            #1;
            chk($sformatf("w1c_sum[%0d]", i), 32'(sum1c), 32'(tab1[i].sum));
            chk($sformatf("w1c_cout[%0d]", i), 32'(cout1c), 32'(tab1[i].cout));
        end

        // Reset held with (1,1,1) applied
        @(negedge clk);
        a1r = 1'b1; b1r = 1'b1; cin1r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("w1r_hold_rst_sum[%0d]", i), 32'(sum1r), 32'd0);
            chk($sformatf("w1r_hold_rst_cout[%0d]", i), 32'(cout1r), 32'd0);
        end
        @(negedge clk);
        rst1 = 1'b0;
        @(posedge clk); #1;
        chk("w1r_release_sum", 32'(sum1r), 32'd1);
        chk("w1r_release_cout", 32'(cout1r), 32'd1);

        // Latency: prior value holds until the edge
        @(negedge clk);
        a1r = 1'b0; b1r = 1'b0; cin1r = 1'b0;
        @(posedge clk); #1;
        chk("w1r_zero_sum", 32'(sum1r), 32'd0);
        chk("w1r_zero_cout", 32'(cout1r), 32'd0);
        @(negedge clk);
        a1r = 1'b1; b1r = 1'b1; cin1r = 1'b1;
        #1;
        chk("w1r_before_edge_sum", 32'(sum1r), 32'd0);
        chk("w1r_before_edge_cout", 32'(cout1r), 32'd0);
        @(posedge clk); #1;
        chk("w1r_after_edge_sum", 32'(sum1r), 32'd1);
        chk("w1r_after_edge_cout", 32'(cout1r), 32'd1);

        // WIDTH=8 directed vectors, including full ripple and overflow
        @(negedge clk);
        rst8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = tab8[i].a; b8 = tab8[i].b; cin8 = tab8[i].cin;
            @(posedge clk); #1;
            chk($sformatf("w8_sum[%0d]", i), 32'(sum8), 32'(tab8[i].sum));
            chk($sformatf("w8_cout[%0d]", i), 32'(cout8), 32'(tab8[i].cout));
        end

        // Back-to-back random traffic with one mid-stream reset cycle
        rst_cycle = 500;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            rst8 = (i == rst_cycle);
            e = (i == rst_cycle) ? 9'd0 : ref_add8(a8, b8, cin8);
            @(posedge clk); #1;
            chk($sformatf("w8_rand[%0d]", i), {23'd0, cout8, sum8}, {23'd0, e});
        end
        @(negedge clk);
        rst8 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
